phy_tx_scheduler: RTL
=====================

Name: phy_tx_scheduler

Overview:
Transmit-side controller that feeds the 32-bit PHY datapath (data_in/valid_in/sincronizar_bus of the PHY top) in the clk_2f domain. After reset it sequences a fixed sync-training pattern on the bus. It then shares the single PHY input between NUM_REQ requesters using round-robin, burst-granular arbitration. IDLE_WORD is driven whenever no burst is active.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 32, datapath width
SYNC_CYCLES, 8, COM_WORD beats sent after reset
MAX_BURST, 8, maximum beats per grant before forced re-arbitration
GNT_W, 2, width of grant index (ceil log2 of NUM_REQ, minimum 1)

Ports:
clk_2f  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  final beat of requester's packet
req_ready  out  NUM_REQ  per-requester accept
phy_data  out  DATA_W  to PHY data_in
phy_valid  out  1  to PHY valid_in
sincronizar_bus  out  1  to PHY; high during sync training
grant  out  GNT_W  index of current or last granted requester
busy  out  1  high in BURST state

Behaviour:
- Reset (async assert, released on clock edge): state=SYNC, sync_cnt=0, beat_cnt=0, rr_ptr=0, grant=0, phy_data=0, phy_valid=0, sincronizar_bus=0, busy=0.
- Registered outputs: phy_data, phy_valid, sincronizar_bus, grant, busy.
- req_ready[i] is combinational: (state==BURST) && (grant==i). It is never high in SYNC or IDLE.
- SYNC:
  - Each cycle: phy_data<=COM_WORD, phy_valid<=1, sincronizar_bus<=1, sync_cnt++.
  - After SYNC_CYCLES beats, go to IDLE. The exact beat count is SYNC_CYCLES.
  - req_valid is ignored.
- IDLE:
  - Each cycle: phy_data<=IDLE_WORD, phy_valid<=0, sincronizar_bus<=0.
  - If any req_valid is high, select the first valid requester at or after rr_ptr (wrapping modulo NUM_REQ). Latch grant, clear beat_cnt, go to BURST.
- BURST:
  - Transfer occurs when req_valid[grant]&&req_ready[grant]. On transfer: phy_data<=req_data[grant], phy_valid<=1, beat_cnt++.
  - With no transfer (bubble): phy_data<=IDLE_WORD, phy_valid<=0; stay in BURST; the grant is held.
  - Exit when a transfer has req_last=1 or beat_cnt reaches MAX_BURST. On exit: rr_ptr<=(grant+1) mod NUM_REQ, go to IDLE.
- Latency:
  - req_valid rising in IDLE -> grant/busy on the next edge -> first beat accepted that cycle -> phy_valid one edge later. Two cycles from req_valid to phy_valid.
  - At least one IDLE cycle separates consecutive bursts.
- Boundaries:
  - last and MAX_BURST coincide: a single exit, the pointer advances once.
  - Non-granted requesters are held off with ready=0; their data must remain stable.
  - Reset mid-burst: everything returns to reset values and a full SYNC is replayed; a partial packet is dropped silently.
  - A burst truncated by MAX_BURST is continued by a later grant to the same requester.
- Arithmetic: beat_cnt width is clog2(MAX_BURST+1). sync_cnt width is clog2(SYNC_CYCLES+1). Neither counter wraps.

Optional Feature:
PHY_TX_SCHED_RESYNC_EN:
- Defined:
  - Adds input resync_req (1 bit). A high cycle sets a sticky pending flag.
  - In IDLE, a pending flag takes priority over arbitration: clear the flag, clear sync_cnt, enter SYNC (full SYNC_CYCLES replay).
  - In BURST, the flag waits for the burst exit.
- Undefined: the port is absent; SYNC is entered only from reset.

Decomposition:
- Package phy_pkg holds:
  - COM_WORD=32'hBCBC_BCBC and IDLE_WORD=32'h7C7C_7C7C.
  - State encoding localparams: SYNC=2'd0, IDLE=2'd1, BURST=2'd2.
- One sub-module, rr_arbiter: combinational round-robin select.
  - Inputs: req vector and rr_ptr.
  - Outputs: any_req and winner index.
- The FSM, counters and output registers remain in phy_tx_scheduler.

Test Plan:
1. Release reset, no requests -> exactly 8 cycles of phy_data=BCBC_BCBC with phy_valid=1 and sincronizar_bus=1, then phy_data=7C7C_7C7C with phy_valid=0 continuously.
2. Req0 sends FFFF_FFFF, EEEE_EEEE, DDDD_DDDD, CCCC_CCCC with last on the 4th beat -> same four words on phy_data with phy_valid=1. First word 2 cycles after req_valid. busy drops after beat 4.
3. Req0 and req1 both valid from IDLE, 4-beat packets each -> grant 0 burst, one idle cycle, grant 1 burst; next contention grants 0 again.
4. Req1 streams 10 beats with no last -> 8 beats forwarded, one idle, re-grant to req1 if alone; the remaining 2 beats follow.
5. Req0 drops valid for 2 cycles mid-burst -> 2 cycles of phy_valid=0/IDLE_WORD, grant held, burst resumes.
6. Assert reset during beat 3 of a burst -> outputs zero immediately; after release a full 8-beat SYNC replays. With RESYNC_EN: resync_req pulsed mid-burst -> SYNC starts after the last beat.

Source files
------------

// File: rtl/phy_tx_scheduler_pkg.sv
// Shared constants and FSM encoding for the PHY transmit scheduler.
package phy_pkg;

   localparam logic [31:0] COM_WORD  = 32'hBCBC_BCBC;
   localparam logic [31:0] IDLE_WORD = 32'h7C7C_7C7C;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      IDLE  = 2'd1,
      BURST = 2'd2
   } state_t;

endpackage

// File: rtl/phy_tx_scheduler_if.sv
// Requester-side and PHY-side bundle of the transmit scheduler.
// resync_req exists only when PHY_TX_SCHED_RESYNC_EN is defined.
interface phy_tx_scheduler_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int GNT_W   = 2
);
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         phy_data;
   logic                      phy_valid;
   logic                      sincronizar_bus;
   logic [GNT_W-1:0]          grant;
   logic                      busy;
`ifdef PHY_TX_SCHED_RESYNC_EN
   logic                      resync_req;
`endif

   modport master (
      output req_data, req_valid, req_last,
`ifdef PHY_TX_SCHED_RESYNC_EN
             resync_req,
`endif
      input  req_ready, phy_data, phy_valid, sincronizar_bus, grant, busy
   );

   modport slave (
      input  req_data, req_valid, req_last,
`ifdef PHY_TX_SCHED_RESYNC_EN
             resync_req,
`endif
      output req_ready, phy_data, phy_valid, sincronizar_bus, grant, busy
   );

endinterface

// File: rtl/phy_tx_scheduler_rr_arbiter.sv
// Combinational round-robin select: first asserted request at or after
// rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int GNT_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GNT_W-1:0]   rr_ptr,
   output logic               any_req,
   output logic [GNT_W-1:0]   winner
);
   localparam int SLOTS = 2**GNT_W;

   logic [SLOTS-1:0] req_ext;
   assign req_ext = SLOTS'(req);

   always_comb begin
      logic [GNT_W-1:0] idx;
      any_req = 1'b0;
      winner  = rr_ptr;
      idx     = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_req && req_ext[idx]) begin
            any_req = 1'b1;
            winner  = idx;
         end
         idx = (idx == GNT_W'(NUM_REQ - 1)) ? '0 : idx + GNT_W'(1);
      end
   end

endmodule

// File: rtl/phy_tx_scheduler.sv
// Sync training followed by burst-granular round-robin sharing of the PHY input.
// Optional PHY_TX_SCHED_RESYNC_EN adds a requested return to sync training.
//
// state | meaning
// SYNC  | drive COM_WORD with sincronizar_bus for SYNC_CYCLES beats
// IDLE  | drive IDLE_WORD, arbitrate (or start a pending resync)
// BURST | forward beats from the granted requester until last or MAX_BURST
module phy_tx_scheduler
   import phy_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int DATA_W      = 32,
   parameter int SYNC_CYCLES = 8,
   parameter int MAX_BURST   = 8,
   parameter int GNT_W       = 2
) (
   input  logic                clk_2f,
   input  logic                reset,
   phy_tx_scheduler_if.slave   bus
);
   localparam int SLOTS = 2**GNT_W;
   localparam int SW    = $clog2(SYNC_CYCLES + 1);
   localparam int BW    = $clog2(MAX_BURST + 1);

   state_t            state_q, state_d;
   logic [SW-1:0]     sync_cnt_q, sync_cnt_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [GNT_W-1:0]  rr_q, rr_d;
   logic [GNT_W-1:0]  grant_q, grant_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              sinc_q, sinc_d;
   logic              busy_q, busy_d;
   logic              any_req;
   logic [GNT_W-1:0]  winner;

   // Pad per-requester signals to a power of two so grant indexes cleanly.
   logic [DATA_W-1:0] data_arr [SLOTS];
   logic [SLOTS-1:0]  valid_ext, last_ext;
   assign valid_ext = SLOTS'(bus.req_valid);
   assign last_ext  = SLOTS'(bus.req_last);

   for (genvar g = 0; g < SLOTS; g++) begin : g_unpack
      if (g < NUM_REQ) begin : g_live
         assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
      end else begin : g_pad
         assign data_arr[g] = '0;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
      assign bus.req_ready[g] = (state_q == BURST) && (grant_q == GNT_W'(g));
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .GNT_W(GNT_W)) u_arb (
      .req     (bus.req_valid),
      .rr_ptr  (rr_q),
      .any_req (any_req),
      .winner  (winner)
   );

`ifdef PHY_TX_SCHED_RESYNC_EN
   logic pend_q, pend_take;
   always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) pend_q <= 1'b0;
      else       pend_q <= (pend_q & ~pend_take) | bus.resync_req;
   end
`endif

   always_comb begin
      state_d    = state_q;
      sync_cnt_d = sync_cnt_q;
      beat_d     = beat_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      data_d     = DATA_W'(IDLE_WORD);
      valid_d    = 1'b0;
      sinc_d     = 1'b0;
      busy_d     = 1'b0;
`ifdef PHY_TX_SCHED_RESYNC_EN
      pend_take  = 1'b0;
`endif
      case (state_q)
         SYNC: begin
            data_d     = DATA_W'(COM_WORD);
            valid_d    = 1'b1;
            sinc_d     = 1'b1;
            sync_cnt_d = sync_cnt_q + SW'(1);
            if (sync_cnt_q == SW'(SYNC_CYCLES - 1)) state_d = IDLE;
         end
         IDLE: begin
`ifdef PHY_TX_SCHED_RESYNC_EN
            if (pend_q) begin
               pend_take  = 1'b1;
               sync_cnt_d = '0;
               state_d    = SYNC;
            end else
`endif
            if (any_req) begin
               grant_d = winner;
               beat_d  = '0;
               busy_d  = 1'b1;
               state_d = BURST;
            end
         end
         BURST: begin
            busy_d = 1'b1;
            if (valid_ext[grant_q]) begin
               data_d  = data_arr[grant_q];
               valid_d = 1'b1;
               beat_d  = beat_q + BW'(1);
               // last and the beat limit coinciding is still one exit.
               if (last_ext[grant_q] || beat_q == BW'(MAX_BURST - 1)) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
                  rr_d    = (grant_q == GNT_W'(NUM_REQ - 1)) ? '0 : grant_q + GNT_W'(1);
               end
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
         state_q    <= SYNC;
         sync_cnt_q <= '0;
         beat_q     <= '0;
         rr_q       <= '0;
         grant_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sinc_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_cnt_q <= sync_cnt_d;
         beat_q     <= beat_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sinc_q     <= sinc_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.phy_data        = data_q;
   assign bus.phy_valid       = valid_q;
   assign bus.sincronizar_bus = sinc_q;
   assign bus.grant           = grant_q;
   assign bus.busy            = busy_q;

endmodule
